dbus_rdmux_sync: RTL and testbench

// - Registered, parametrised read-data multiplexer between NCH peripheral data buses (UARTs, PIC, ...) and CPU bus.
// - Adds per-channel wait states, ready handshake, stable hold until cycle end, multi-select error capture.
// - Sits between the address decoder (one chip select per peripheral) and the FPGA data-bus output drivers.

---
 rtl/dbus_rdmux_sync_pkg.sv | 18 +
 rtl/dbus_rdmux_sync_onehot_enc.sv | 24 ++
 rtl/dbus_rdmux_sync.sv | 137 +++++++++++++
 tb/tb_dbus_rdmux_sync.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dbus_rdmux_sync_pkg.sv
// Shared types and helpers for the peripheral read-data mux.
// Imported by the one-hot encoder and the mux top.
package dbus_pkg;

  localparam int DBUS_BW = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dbus_rdmux_sync_onehot_enc.sv
// Chip-select one-hot check and binary index encoder.
// Purely combinational; the index is only meaningful when o_onehot is set.
module dbus_onehot_enc
  import dbus_pkg::*;
#(
  parameter int NCH = 5,
  parameter int IW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] i_cs,
  output logic           o_onehot,
  output logic [IW-1:0]  o_idx
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (i_cs[i]) o_idx = o_idx | IW'(i);
    end
  end

  assign o_onehot = (i_cs != '0) &&
                    ((i_cs & (i_cs - 1'b1)) == '0);

endmodule

// File: rtl/dbus_rdmux_sync.sv
// Registered read-data mux with per-channel wait states,
// ready handshake, hold-until-cycle-end and multi-select error capture.
module dbus_rdmux_sync
  import dbus_pkg::*;
#(
  parameter int BW     = DBUS_BW,
  parameter int NCH    = 5,
  parameter int WAIT_W = 3,
  parameter logic [NCH*WAIT_W-1:0] WAIT_CYC = '0
) (
  input  logic              i_clk,
  input  logic              i_nreset,
  input  logic [NCH-1:0]    i_cs,
  input  logic              i_nrw,
  input  logic [NCH*BW-1:0] i_di,
  input  logic              i_err_clr,
  output logic [BW-1:0]     o_do,
  output logic              o_do_oe,
  output logic              o_rdy,
  output logic              o_err_multi
);

  localparam int IW = idx_w(NCH);

  state_t            r_state;
  logic [WAIT_W-1:0] r_cnt;
  logic [IW-1:0]     r_idx;
  logic [NCH-1:0]    r_cs;
  logic [BW-1:0]     r_do;
  logic              r_oe;
  logic              r_rdy;
  logic              r_err;

  logic              w_rd;
  logic              w_onehot;
  logic              w_multi;
  logic              w_abort;
  logic [IW-1:0]     w_idx;
  logic [WAIT_W-1:0] w_wait;
  logic [BW-1:0]     w_dsel;

  dbus_onehot_enc #(
    .NCH (NCH),
    .IW  (IW)
  ) u_enc (
    .i_cs     (i_cs),
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );

  assign w_rd    = ~i_nrw & (|i_cs);
  assign w_multi = w_rd & ~w_onehot;
  assign w_abort = ~w_rd | (i_cs != r_cs);

  // wait count follows the live select, data follows the latched one
  always_comb begin
    w_wait = '0;
    w_dsel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_idx == IW'(i))
        w_wait = WAIT_CYC[i*WAIT_W +: WAIT_W];
      if (r_idx == IW'(i))
        w_dsel = i_di[i*BW +: BW];
    end
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_err <= 1'b0;
    end else if (w_multi) begin
      r_err <= 1'b1;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_cs    <= '0;
      r_do    <= '0;
      r_oe    <= 1'b0;
      r_rdy   <= 1'b0;
    end else if (w_multi) begin
      r_state <= S_IDLE;
      r_oe    <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_oe  <= 1'b0;
          r_rdy <= 1'b0;
          if (w_rd) begin
            r_idx   <= w_idx;
            r_cs    <= i_cs;
            r_cnt   <= w_wait;
            r_state <= (w_wait == '0) ? S_CAPT : S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == WAIT_W'(1)) r_state <= S_CAPT;
          end
        end
        S_CAPT: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_do    <= w_dsel;
            r_oe    <= 1'b1;
            r_rdy   <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_abort) begin
            r_oe    <= 1'b0;
            r_rdy   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_do        = r_do;
  assign o_do_oe     = r_oe;
  assign o_rdy       = r_rdy;
  assign o_err_multi = r_err;

endmodule

// File: tb/tb_dbus_rdmux_sync.sv
// Directed-vector bench for dbus_rdmux_sync.
// Waits per channel: ch0=1 ch1=0 ch2=3 ch3=4 ch4=2.
module tb_dbus_rdmux_sync;

  localparam int BW  = 16;
  localparam int NCH = 5;
  localparam int WW  = 3;
  localparam logic [NCH*WW-1:0] WCYC =
    {3'd2, 3'd4, 3'd3, 3'd0, 3'd1};

  logic              clk;
  logic              nreset;
  logic [NCH-1:0]    cs;
  logic              nrw;
  logic [NCH*BW-1:0] di;
  logic              err_clr;
  logic [BW-1:0]     dout;
  logic              do_oe;
  logic              rdy;
  logic              err_multi;

  int n_vec;
  int n_bad;

  dbus_rdmux_sync #(
    .BW       (BW),
    .NCH      (NCH),
    .WAIT_W   (WW),
    .WAIT_CYC (WCYC)
  ) dut (
    .i_clk       (clk),
    .i_nreset    (nreset),
    .i_cs        (cs),
    .i_nrw       (nrw),
    .i_di        (di),
    .i_err_clr   (err_clr),
    .o_do        (dout),
    .o_do_oe     (do_oe),
    .o_rdy       (rdy),
    .o_err_multi (err_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_di(input int ch, input logic [BW-1:0] v);
    di[ch*BW +: BW] = v;
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    nreset  = 1'b0;
    cs      = '0;
    nrw     = 1'b1;
    di      = '0;
    err_clr = 1'b0;
    #3;
    chk("rst_do",  32'(dout), 32'h0);
    chk("rst_oe",  32'(do_oe), 32'h0);
    chk("rst_rdy", 32'(rdy), 32'h0);
    chk("rst_err", 32'(err_multi), 32'h0);
    tick();
    nreset = 1'b1;
    tick();

    // ch1, zero wait, then hold while peripheral data moves
    set_di(1, 16'hA55A);
    set_di(3, 16'hBEEF);
    set_di(0, 16'h0C0C);
    set_di(2, 16'h2222);
    set_di(4, 16'h4444);
    cs  = 5'b00010;
    nrw = 1'b0;
    tick();
    chk("w0_rdy_e0", 32'(rdy), 32'h0);
    tick();
    chk("w0_do",  32'(dout), 32'hA55A);
    chk("w0_oe",  32'(do_oe), 32'h1);
    chk("w0_rdy", 32'(rdy), 32'h1);
    set_di(1, 16'h1234);
    tick();
    chk("hold_do",  32'(dout), 32'hA55A);
    chk("hold_rdy", 32'(rdy), 32'h1);

    // async reset mid-HOLD, observed before the next edge
    #2 nreset = 1'b0;
    #1;
    chk("mrst_do",  32'(dout), 32'h0);
    chk("mrst_oe",  32'(do_oe), 32'h0);
    chk("mrst_rdy", 32'(rdy), 32'h0);
    chk("mrst_err", 32'(err_multi), 32'h0);
    cs  = '0;
    nrw = 1'b1;
    #2 nreset = 1'b1;
    tick();

    // ch3, four wait states
    cs  = 5'b01000;
    nrw = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      tick();
      chk($sformatf("w4_rdy_e%0d", e), 32'(rdy), 32'h0);
    end
    tick();
    chk("w4_rdy_e5", 32'(rdy), 32'h1);
    chk("w4_do",     32'(dout), 32'hBEEF);
    nrw = 1'b1;
    tick();
    chk("w4_end_rdy", 32'(rdy), 32'h0);
    chk("w4_end_oe",  32'(do_oe), 32'h0);
    chk("w4_end_do",  32'(dout), 32'hBEEF);

    // multi-select error, set beats clear
    cs  = 5'b10010;
    nrw = 1'b0;
    tick();
    chk("mul_err", 32'(err_multi), 32'h1);
    chk("mul_oe",  32'(do_oe), 32'h0);
    err_clr = 1'b1;
    tick();
    chk("mul_setwin", 32'(err_multi), 32'h1);
    chk("mul_rdy",    32'(rdy), 32'h0);
    cs = '0;
    tick();
    chk("mul_clr", 32'(err_multi), 32'h0);
    err_clr = 1'b0;
    nrw     = 1'b1;
    tick();

    // abort ch2 at cnt=2, then ch0 completes with wait 1
    cs  = 5'b00100;
    nrw = 1'b0;
    tick();
    tick();
    cs = 5'b00001;
    tick();
    chk("ab_e2_rdy", 32'(rdy), 32'h0);
    tick();
    chk("ab_e3_rdy", 32'(rdy), 32'h0);
    tick();
    chk("ab_e4_rdy", 32'(rdy), 32'h0);
    tick();
    chk("ab_e5_rdy", 32'(rdy), 32'h1);
    chk("ab_do",     32'(dout), 32'h0C0C);
    cs  = '0;
    nrw = 1'b1;
    tick();

    // write cycles never drive
    cs  = 5'b00001;
    nrw = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("wr_c%0d", c), {30'h0, do_oe, rdy}, 32'h0);
    end

    // ch4 read, then switch to ch1 while in HOLD
    cs  = 5'b10000;
    nrw = 1'b0;
    tick();
    tick();
    tick();
    chk("sw_pre_rdy", 32'(rdy), 32'h0);
    tick();
    chk("sw_ch4_rdy", 32'(rdy), 32'h1);
    chk("sw_ch4_do",  32'(dout), 32'h4444);
    cs = 5'b00010;
    tick();
    chk("sw_drop_rdy", 32'(rdy), 32'h0);
    chk("sw_keep_do",  32'(dout), 32'h4444);
    tick();
    chk("sw_capt_rdy", 32'(rdy), 32'h0);
    tick();
    chk("sw_ch1_rdy", 32'(rdy), 32'h1);
    chk("sw_ch1_do",  32'(dout), 32'h1234);
    cs  = '0;
    nrw = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
